// File: rtl/paddle_encoder_pkg.sv
// paddle_encoder_pkg: quadrature constants, accumulator limits and CW sequencing helper
package paddle_encoder_pkg;
    localparam logic [1:0] DETENT = 2'b00;
    localparam int ACC_W = 4;
    localparam logic signed [ACC_W-1:0] ACC_HI = 4'sd4;
    localparam logic signed [ACC_W-1:0] ACC_LO = -4'sd4;
    localparam logic signed [ACC_W-1:0] ACC_ONE = 4'sd1;
    // CW order 00->10->11->01->00
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        return {~ab[0], ab[1]};
    endfunction
endpackage

// File: rtl/paddle_encoder_quad_step.sv
// quad_step: quadrature decoder with saturating quarter-step accumulator and detent pulses
module quad_step
    import paddle_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_ab,
    output logic       o_up_nxt,
    output logic       o_dn_nxt,
    output logic       o_step_up,
    output logic       o_step_down,
    output logic       o_error
);
    logic [1:0] r_ab_prev;
    logic signed [ACC_W-1:0] r_acc, w_acc_mv, w_acc_nxt;
    logic w_same, w_illegal, w_cw, w_home;
    assign w_same    = i_ab == r_ab_prev;
    assign w_illegal = (i_ab ^ r_ab_prev) == 2'b11;
    assign w_cw      = i_ab == cw_next(r_ab_prev);
    assign w_home    = !w_same && !w_illegal && i_ab == DETENT;
    assign w_acc_mv  = w_cw ? (r_acc == ACC_HI ? ACC_HI : r_acc + ACC_ONE)
                            : (r_acc == ACC_LO ? ACC_LO : r_acc - ACC_ONE);
    assign w_acc_nxt = w_same ? r_acc : (w_illegal || w_home) ? '0 : w_acc_mv;
    assign o_up_nxt  = w_home && w_acc_mv == ACC_HI;
    assign o_dn_nxt  = w_home && w_acc_mv == ACC_LO;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ab_prev   <= DETENT;
            r_acc       <= '0;
            o_step_up   <= 1'b0;
            o_step_down <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            r_ab_prev   <= i_ab;
            r_acc       <= w_acc_nxt;
            o_step_up   <= o_up_nxt;
            o_step_down <= o_dn_nxt;
            o_error     <= w_illegal;
        end
    end
endmodule

// File: rtl/paddle_encoder.sv
// paddle_encoder: quadrature decode into a saturating, holdable paddle position
module paddle_encoder
    import paddle_encoder_pkg::*;
#(
    parameter int POS_W    = 8,
    parameter int POS_MAX  = 200,
    parameter int POS_INIT = 100,
    parameter int STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             hold,
    output logic [POS_W-1:0] position,
    output logic             step_up,
    output logic             step_down,
    output logic             error
);
    localparam logic [POS_W:0] MAX_W  = POS_MAX[POS_W:0];
    localparam logic [POS_W:0] STEP_W = STEP[POS_W:0];
    localparam logic [POS_W:0] INIT_W = POS_INIT[POS_W:0];
    logic [POS_W-1:0] r_position, w_up_sat, w_dn_sat;
    logic [POS_W:0] w_up, w_dn;
    logic w_up_nxt, w_dn_nxt;
    quad_step u_quad (
        .clk         (clk),
        .reset       (reset),
        .i_ab        ({enc_a, enc_b}),
        .o_up_nxt    (w_up_nxt),
        .o_dn_nxt    (w_dn_nxt),
        .o_step_up   (step_up),
        .o_step_down (step_down),
        .o_error     (error)
    );
    // a borrow lands in the extra MSB, marking underflow
    assign w_up     = {1'b0, r_position} + STEP_W;
    assign w_dn     = {1'b0, r_position} - STEP_W;
    assign w_up_sat = w_up > MAX_W ? MAX_W[POS_W-1:0] : w_up[POS_W-1:0];
    assign w_dn_sat = w_dn[POS_W] ? '0 : w_dn[POS_W-1:0];
    assign position = r_position;
    always_ff @(posedge clk) begin
        if (reset)
            r_position <= INIT_W[POS_W-1:0];
        else if (!hold && w_up_nxt)
            r_position <= w_up_sat;
        else if (!hold && w_dn_nxt)
            r_position <= w_dn_sat;
    end
endmodule
